mem_stall_ctrl: RTL and testbench
=================================

MEM_STALL_CTRL -- requirements
Module: mem_stall_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: cpu_clk_50M and cpu_rst.
REQ-002 Parameter SHALL be TIMEOUT, default 15, meaning the highest BUSY-cycle count index; the bus is aborted after TIMEOUT+1 BUSY cycles without ack.
REQ-003 Ports SHALL be, in order:
- cpu_clk_50M  in  1  clock, rising edge
- cpu_rst  in  1  async reset, active-high
- mem_req  in  1  MEM-stage instruction is a load/store
- mem_we  in  1  1 = store
- mem_addr  in  32  byte address
- mem_wdata  in  32  store data
- mem_sel  in  4  byte enables
- flush  in  1  MEM-stage instruction is cancelled
- bus_ack  in  1  data-bus completion
- bus_rdata  in  32  data-bus read data
- stall_from_mem  out  1  STOP (1) = freeze the pipeline
- bus_req  out  1  data-bus request
- bus_we, bus_addr, bus_wdata, bus_sel  out  1/32/32/4  latched copies of the mem_* request fields
- mem_rdata  out  32  load result
- bus_err  out  1  one-cycle timeout pulse

Function
REQ-004 The FSM SHALL have three states: IDLE, BUSY, DONE; state SHALL be registered.
REQ-005 In IDLE, stall_from_mem SHALL equal mem_req & ~flush combinationally, so the stall asserts in the same cycle the request appears.
REQ-006 In IDLE with mem_req=1 and flush=0, the block SHALL, at the clock edge:
- latch mem_we/addr/wdata/sel into bus_*
- clear the timeout counter
- go to BUSY
REQ-007 In IDLE with mem_req=0 or flush=1, the FSM SHALL stay in IDLE and launch no bus cycle.
REQ-008 bus_req SHALL be 1 exactly while state==BUSY; bus_* fields SHALL stay stable for the whole of BUSY.
REQ-009 In BUSY, stall_from_mem SHALL be 1 regardless of mem_req, flush or bus_ack.
REQ-010 In BUSY with bus_ack=1 at an edge, the block SHALL:
- load mem_rdata with bus_rdata if bus_we=0; leave it unchanged if bus_we=1
- go to DONE
REQ-011 In BUSY with bus_ack=0, the 4-bit counter SHALL increment each edge. When the counter==TIMEOUT and bus_ack=0 at an edge, the block SHALL:
- load mem_rdata with 0 (reads only)
- set bus_err for the following (DONE) cycle
- go to DONE
REQ-012 bus_ack arriving in the same edge as the timeout condition SHALL win: the transfer completes normally with no bus_err.
REQ-013 DONE SHALL last exactly one cycle, with stall_from_mem=0 and bus_req=0, then return to IDLE; mem_req is ignored in DONE so the same instruction is not reissued.
REQ-014 flush during BUSY SHALL NOT abort the bus cycle (bus protocol holds req until ack or timeout); completion still proceeds to DONE.
REQ-015 bus_ack while in IDLE or DONE SHALL be ignored.
REQ-016 Minimum latency for an ack on the first BUSY cycle SHALL be:
- stall high for 2 cycles (IDLE, BUSY)
- mem_rdata valid in the 3rd cycle (DONE)
REQ-017 mem_rdata SHALL hold its value until the next completed read or timeout.

Reset
REQ-018 On cpu_rst=1, immediately and without a clock, the block SHALL force:
- state=IDLE, counter=0
- bus_req=0, bus_err=0
- bus_we/addr/wdata/sel=0, mem_rdata=0
REQ-019 While cpu_rst=1, stall_from_mem SHALL be 0.
REQ-020 Reset asserted mid-BUSY SHALL drop bus_req in the same cycle and discard the transfer.

Verification
REQ-021 Read, ack on first BUSY cycle, bus_rdata=0xDEADBEEF -> stall 1,1,0; bus_req high 1 cycle; mem_rdata=0xDEADBEEF in DONE.
REQ-022 Store addr=0x100, wdata=0x12345678, sel=4'b0011, ack after 3 BUSY cycles -> bus_* stable all 3 cycles; stall high 4 cycles; mem_rdata unchanged.
REQ-023 Read with no ack -> bus_req high 16 cycles; bus_err=1 for one cycle; mem_rdata=0; stall drops in the DONE cycle.
REQ-024 Ack on the 16th BUSY cycle -> normal completion, bus_err=0.
REQ-025 Both of the following:
- mem_req=1 with flush=1 in IDLE -> stall=0, no bus_req
- flush=1 during BUSY -> transfer still completes
REQ-026 cpu_rst pulsed during BUSY -> bus_req and stall go 0 asynchronously; next mem_req starts a fresh transfer from IDLE.

Source files
------------

// File: rtl/mem_stall_ctrl_if.sv
//------------------------------------------------------------------------------
// mem_stall_ctrl_if : MEM-stage request and data-bus signal bundle
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface mem_stall_ctrl_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_sel;
  logic        flush;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        stall_from_mem;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_sel;
  logic [31:0] mem_rdata;
  logic        bus_err;

  // Controller side
  modport master (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_sel, flush, bus_ack, bus_rdata,
    output stall_from_mem, bus_req, bus_we, bus_addr, bus_wdata, bus_sel, mem_rdata, bus_err
  );

  // Pipeline / bus side
  modport slave (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_sel, flush, bus_ack, bus_rdata,
    input  stall_from_mem, bus_req, bus_we, bus_addr, bus_wdata, bus_sel, mem_rdata, bus_err
  );
endinterface

`default_nettype wire

// File: rtl/mem_stall_ctrl.sv
//------------------------------------------------------------------------------
// mem_stall_ctrl : freezes the pipeline while a MEM-stage load/store runs on the
//                  data bus, with a BUSY-cycle timeout that aborts the transfer
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mem_stall_ctrl #(
  parameter int TIMEOUT = 15
) (
  input  logic              cpu_clk_50M,
  input  logic              cpu_rst,
  mem_stall_ctrl_if.master  mif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] TIMEOUT_CNT = 4'(TIMEOUT);

  state_t     state;
  state_t     next_state;
  logic [3:0] count;
  logic       launch;
  logic       ack_hit;
  logic       timeout_hit;

  assign launch      = (state == IDLE) && mif.mem_req && !mif.flush;
  assign ack_hit     = (state == BUSY) && mif.bus_ack;
  // Ack on the final BUSY cycle takes priority over the timeout
  assign timeout_hit = (state == BUSY) && !mif.bus_ack && (count == TIMEOUT_CNT);

  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (launch) next_state = BUSY;
      BUSY:    if (ack_hit || timeout_hit) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign mif.bus_req = (state == BUSY);

  always_comb begin
    mif.stall_from_mem = 1'b0;
    if (!cpu_rst) begin
      case (state)
        IDLE:    mif.stall_from_mem = mif.mem_req && !mif.flush;
        BUSY:    mif.stall_from_mem = 1'b1;
        default: mif.stall_from_mem = 1'b0;
      endcase
    end
  end

  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      count         <= 4'd0;
      mif.bus_err   <= 1'b0;
      mif.bus_we    <= 1'b0;
      mif.bus_addr  <= 32'd0;
      mif.bus_wdata <= 32'd0;
      mif.bus_sel   <= 4'd0;
      mif.mem_rdata <= 32'd0;
    end else begin
      mif.bus_err <= 1'b0;
      if (launch) begin
        mif.bus_we    <= mif.mem_we;
        mif.bus_addr  <= mif.mem_addr;
        mif.bus_wdata <= mif.mem_wdata;
        mif.bus_sel   <= mif.mem_sel;
        count         <= 4'd0;
      end
      if (ack_hit) begin
        if (!mif.bus_we) mif.mem_rdata <= mif.bus_rdata;
      end else if (timeout_hit) begin
        if (!mif.bus_we) mif.mem_rdata <= 32'd0;
        mif.bus_err <= 1'b1;
      end else if (state == BUSY) begin
        count <= count + 4'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_stall_ctrl.sv
//------------------------------------------------------------------------------
// tb_mem_stall_ctrl : directed self-checking bench for mem_stall_ctrl
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_stall_ctrl;

  logic cpu_clk_50M;
  logic cpu_rst;
  int   n_checks;
  int   n_fail;

  mem_stall_ctrl_if mif ();

  mem_stall_ctrl #(.TIMEOUT(15)) dut (
    .cpu_clk_50M (cpu_clk_50M),
    .cpu_rst     (cpu_rst),
    .mif         (mif)
  );

  initial cpu_clk_50M = 1'b0;
  always #10 cpu_clk_50M = ~cpu_clk_50M;

  // Inputs change and outputs are sampled 1 time unit after the rising edge
  task automatic tick();
    @(posedge cpu_clk_50M);
    #1;
  endtask

  task automatic idle_inputs();
    mif.mem_req   = 1'b0;
    mif.mem_we    = 1'b0;
    mif.mem_addr  = 32'd0;
    mif.mem_wdata = 32'd0;
    mif.mem_sel   = 4'd0;
    mif.flush     = 1'b0;
    mif.bus_ack   = 1'b0;
    mif.bus_rdata = 32'd0;
  endtask

  task automatic test_reset();
    cpu_rst = 1'b1;
    idle_inputs();
    mif.mem_req = 1'b1;
    #5;
    n_checks++;
    if (mif.stall_from_mem !== 1'b0) begin
      n_fail++; $display("FAIL reset_stall: got %b expected 0", mif.stall_from_mem);
    end
    n_checks++;
    if (mif.bus_req !== 1'b0 || mif.bus_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_req_err: got req=%b err=%b expected 0/0", mif.bus_req, mif.bus_err);
    end
    n_checks++;
    if (mif.mem_rdata !== 32'd0 || mif.bus_addr !== 32'd0 || mif.bus_sel !== 4'd0) begin
      n_fail++; $display("FAIL reset_regs: got rdata=%h addr=%h sel=%h expected zeros", mif.mem_rdata, mif.bus_addr, mif.bus_sel);
    end
    tick();
    tick();
    mif.mem_req = 1'b0;
    cpu_rst = 1'b0;
    tick();
  endtask

  task automatic test_read_first_ack();
    mif.mem_req = 1'b1; mif.mem_we = 1'b0; mif.mem_addr = 32'h40;
    #1;
    n_checks++;
    if (mif.stall_from_mem !== 1'b1 || mif.bus_req !== 1'b0) begin
      n_fail++; $display("FAIL rd_idle: got stall=%b req=%b expected 1/0", mif.stall_from_mem, mif.bus_req);
    end
    tick();
    mif.bus_ack = 1'b1; mif.bus_rdata = 32'hDEADBEEF;
    #1;
    n_checks++;
    if (mif.stall_from_mem !== 1'b1 || mif.bus_req !== 1'b1 || mif.bus_addr !== 32'h40) begin
      n_fail++; $display("FAIL rd_busy: got stall=%b req=%b addr=%h expected 1/1/00000040", mif.stall_from_mem, mif.bus_req, mif.bus_addr);
    end
    tick();
    mif.bus_ack = 1'b0;
    n_checks++;
    if (mif.stall_from_mem !== 1'b0 || mif.bus_req !== 1'b0 || mif.mem_rdata !== 32'hDEADBEEF || mif.bus_err !== 1'b0) begin
      n_fail++; $display("FAIL rd_done: got stall=%b req=%b rdata=%h err=%b expected 0/0/deadbeef/0", mif.stall_from_mem, mif.bus_req, mif.mem_rdata, mif.bus_err);
    end
    tick();
    n_checks++;
    if (mif.bus_req !== 1'b0) begin
      n_fail++; $display("FAIL rd_no_reissue: got req=%b expected 0", mif.bus_req);
    end
    mif.mem_req = 1'b0;
    tick();
  endtask

  task automatic test_store();
    mif.mem_req = 1'b1; mif.mem_we = 1'b1; mif.mem_addr = 32'h100;
    mif.mem_wdata = 32'h12345678; mif.mem_sel = 4'b0011;
    mif.bus_rdata = 32'hBADBAD00;
    tick();
    // Scramble the request fields to prove bus_* are latched copies
    mif.mem_we = 1'b0; mif.mem_addr = 32'hFFFF_FFFF; mif.mem_wdata = 32'h0; mif.mem_sel = 4'hF;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) mif.bus_ack = 1'b1;
      #1;
      n_checks++;
      if (mif.bus_req !== 1'b1 || mif.stall_from_mem !== 1'b1 || mif.bus_we !== 1'b1 ||
          mif.bus_addr !== 32'h100 || mif.bus_wdata !== 32'h12345678 || mif.bus_sel !== 4'b0011) begin
        n_fail++; $display("FAIL st_busy%0d: got req=%b stall=%b we=%b addr=%h wdata=%h sel=%h expected 1/1/1/00000100/12345678/3",
                           i, mif.bus_req, mif.stall_from_mem, mif.bus_we, mif.bus_addr, mif.bus_wdata, mif.bus_sel);
      end
      tick();
    end
    mif.bus_ack = 1'b0; mif.mem_req = 1'b0;
    n_checks++;
    if (mif.stall_from_mem !== 1'b0 || mif.bus_req !== 1'b0 || mif.mem_rdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL st_done: got stall=%b req=%b rdata=%h expected 0/0/deadbeef", mif.stall_from_mem, mif.bus_req, mif.mem_rdata);
    end
    tick();
  endtask

  task automatic test_timeout();
    int n;
    mif.mem_req = 1'b1; mif.mem_we = 1'b0; mif.mem_addr = 32'h80;
    mif.bus_rdata = 32'h5555AAAA;
    tick();
    mif.mem_req = 1'b0;
    n = 0;
    while (mif.bus_req === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    n_checks++;
    if (n !== 16) begin
      n_fail++; $display("FAIL to_busy_len: got %0d cycles expected 16", n);
    end
    n_checks++;
    if (mif.bus_err !== 1'b1 || mif.mem_rdata !== 32'd0 || mif.stall_from_mem !== 1'b0) begin
      n_fail++; $display("FAIL to_done: got err=%b rdata=%h stall=%b expected 1/00000000/0", mif.bus_err, mif.mem_rdata, mif.stall_from_mem);
    end
    tick();
    n_checks++;
    if (mif.bus_err !== 1'b0) begin
      n_fail++; $display("FAIL to_err_pulse: got err=%b expected 0", mif.bus_err);
    end
  endtask

  task automatic test_ack_at_limit();
    mif.mem_req = 1'b1; mif.mem_we = 1'b0; mif.mem_addr = 32'h84;
    tick();
    mif.mem_req = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    mif.bus_ack = 1'b1; mif.bus_rdata = 32'hA5A55A5A;
    #1;
    n_checks++;
    if (mif.bus_req !== 1'b1) begin
      n_fail++; $display("FAIL lim_busy16: got req=%b expected 1", mif.bus_req);
    end
    tick();
    mif.bus_ack = 1'b0;
    n_checks++;
    if (mif.bus_err !== 1'b0 || mif.mem_rdata !== 32'hA5A55A5A || mif.bus_req !== 1'b0) begin
      n_fail++; $display("FAIL lim_done: got err=%b rdata=%h req=%b expected 0/a5a55a5a/0", mif.bus_err, mif.mem_rdata, mif.bus_req);
    end
    tick();
  endtask

  task automatic test_flush();
    mif.mem_req = 1'b1; mif.mem_we = 1'b0; mif.flush = 1'b1; mif.mem_addr = 32'hC0;
    #1;
    n_checks++;
    if (mif.stall_from_mem !== 1'b0) begin
      n_fail++; $display("FAIL fl_idle_stall: got %b expected 0", mif.stall_from_mem);
    end
    tick();
    n_checks++;
    if (mif.bus_req !== 1'b0) begin
      n_fail++; $display("FAIL fl_idle_req: got %b expected 0", mif.bus_req);
    end
    mif.flush = 1'b0;
    tick();
    mif.flush = 1'b1; mif.mem_req = 1'b0;
    tick();
    n_checks++;
    if (mif.bus_req !== 1'b1 || mif.stall_from_mem !== 1'b1) begin
      n_fail++; $display("FAIL fl_busy: got req=%b stall=%b expected 1/1", mif.bus_req, mif.stall_from_mem);
    end
    mif.bus_ack = 1'b1; mif.bus_rdata = 32'h0BADF00D;
    tick();
    mif.bus_ack = 1'b0; mif.flush = 1'b0;
    n_checks++;
    if (mif.mem_rdata !== 32'h0BADF00D || mif.bus_req !== 1'b0) begin
      n_fail++; $display("FAIL fl_done: got rdata=%h req=%b expected 0badf00d/0", mif.mem_rdata, mif.bus_req);
    end
    tick();
    mif.bus_ack = 1'b1; mif.bus_rdata = 32'hFFFFFFFF;
    tick();
    mif.bus_ack = 1'b0;
    n_checks++;
    if (mif.mem_rdata !== 32'h0BADF00D || mif.bus_req !== 1'b0) begin
      n_fail++; $display("FAIL idle_ack_ignored: got rdata=%h req=%b expected 0badf00d/0", mif.mem_rdata, mif.bus_req);
    end
  endtask

  task automatic test_reset_mid_busy();
    mif.mem_req = 1'b1; mif.mem_we = 1'b0; mif.mem_addr = 32'h200;
    tick();
    #2;
    cpu_rst = 1'b1;
    #1;
    n_checks++;
    if (mif.bus_req !== 1'b0 || mif.stall_from_mem !== 1'b0 || mif.bus_addr !== 32'd0 || mif.mem_rdata !== 32'd0) begin
      n_fail++; $display("FAIL rst_busy: got req=%b stall=%b addr=%h rdata=%h expected 0/0/0/0", mif.bus_req, mif.stall_from_mem, mif.bus_addr, mif.mem_rdata);
    end
    tick();
    cpu_rst = 1'b0;
    mif.mem_addr = 32'h300;
    #1;
    n_checks++;
    if (mif.stall_from_mem !== 1'b1 || mif.bus_req !== 1'b0) begin
      n_fail++; $display("FAIL rst_restart_idle: got stall=%b req=%b expected 1/0", mif.stall_from_mem, mif.bus_req);
    end
    tick();
    mif.bus_ack = 1'b1; mif.bus_rdata = 32'hCAFE0001;
    #1;
    n_checks++;
    if (mif.bus_req !== 1'b1 || mif.bus_addr !== 32'h300) begin
      n_fail++; $display("FAIL rst_restart_busy: got req=%b addr=%h expected 1/00000300", mif.bus_req, mif.bus_addr);
    end
    tick();
    mif.bus_ack = 1'b0; mif.mem_req = 1'b0;
    n_checks++;
    if (mif.mem_rdata !== 32'hCAFE0001) begin
      n_fail++; $display("FAIL rst_restart_done: got rdata=%h expected cafe0001", mif.mem_rdata);
    end
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_read_first_ack();
    test_store();
    test_timeout();
    test_ack_at_limit();
    test_flush();
    test_reset_mid_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
